game_move_sequencer: RTL and testbench

- Stores a programmed sequence of up to DEPTH moves and replays it into the game FSM.
- Drives the one-hot direction inputs n/s/e/w, one move per clock.
- Owns the game's reset during a run.
- Watches the game's d/win outputs and reports the outcome and number of moves issued.
- Sits between a host or bench and the game block.

---
 rtl/game_move_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_game_move_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/game_move_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// game_move_sequencer : buffers up to DEPTH moves and replays them into the
// game FSM, owning its reset during a run and reporting the outcome. Rev 1.0
// ----------------------------------------------------------------------------
module game_move_sequencer #(
   parameter int DEPTH        = 16,
   parameter int CNT_W        = 5,
   parameter int RST_CYCLES   = 5,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [1:0]       load_dir,
   output logic             load_ready,
   input  logic             clear,
   input  logic             start,
   input  logic             abort,
   input  logic             game_d,
   input  logic             game_win,
   output logic             game_reset,
   output logic             n,
   output logic             s,
   output logic             e,
   output logic             w,
   output logic             busy,
   output logic             done,
   output logic [1:0]       result,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] moves
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRST  = 3'd1,
      S_PLAY  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Shared GRST/DRAIN timer; 8 bits covers phase lengths up to 256 cycles.
   localparam int               C_AW         = CNT_W - 1;
   localparam int               C_TW         = 8;
   localparam logic [CNT_W-1:0] C_DEPTH      = CNT_W'(DEPTH);
   localparam logic [C_TW-1:0]  C_RST_LAST   = C_TW'(RST_CYCLES - 1);
   localparam logic [C_TW-1:0]  C_DRAIN_LAST = C_TW'(DRAIN_CYCLES - 1);
   localparam logic [1:0]       C_RES_ABORT  = 2'b00;
   localparam logic [1:0]       C_RES_WIN    = 2'b01;
   localparam logic [1:0]       C_RES_DEAD   = 2'b10;
   localparam logic [1:0]       C_RES_EXH    = 2'b11;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] moves_q, moves_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_TW-1:0]  timer_q, timer_d;
   logic [1:0]       result_q, result_d;
   logic [3:0]       dir_q, dir_d;
   logic             game_reset_q, game_reset_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_ready_q, load_ready_d;
   logic [1:0]       buf_q [DEPTH];

   logic             w_wr_en;
   logic [CNT_W-1:0] w_rd_nxt;
   logic             w_stop;
   logic [1:0]       w_stop_res;

   function automatic logic [3:0] f_decode(input logic [1:0] code);
      return 4'b1000 >> code;
   endfunction

   assign w_rd_nxt   = rd_ptr_q + CNT_W'(1);
   assign w_stop     = abort | game_win | game_d;
   assign w_stop_res = abort ? C_RES_ABORT : (game_win ? C_RES_WIN : C_RES_DEAD);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      moves_d  = moves_q;
      rd_ptr_d = rd_ptr_q;
      timer_d  = timer_q;
      result_d = result_q;
      dir_d    = 4'b0000;
      w_wr_en  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (clear) begin
               count_d = '0;
            end else if (start) begin
               if (count_q != '0) begin
                  state_d  = S_GRST;
                  moves_d  = '0;
                  rd_ptr_d = '0;
                  timer_d  = '0;
               end
            end else if (load_valid && load_ready_q) begin
               w_wr_en = 1'b1;
               count_d = count_q + CNT_W'(1);
            end
         end
         S_GRST: begin
            if (abort) begin
               state_d  = S_DONE;
               result_d = C_RES_ABORT;
            end else if (timer_q == C_RST_LAST) begin
               state_d = S_PLAY;
               dir_d   = f_decode(buf_q[rd_ptr_q[C_AW-1:0]]);
            end else begin
               timer_d = timer_q + C_TW'(1);
            end
         end
         S_PLAY: begin
            // A move that coincides with win/dead/abort is not credited.
            if (w_stop) begin
               state_d  = S_DONE;
               result_d = w_stop_res;
            end else begin
               moves_d  = moves_q + CNT_W'(1);
               rd_ptr_d = w_rd_nxt;
               if (w_rd_nxt == count_q) begin
                  state_d = S_DRAIN;
                  timer_d = '0;
               end else begin
                  dir_d = f_decode(buf_q[w_rd_nxt[C_AW-1:0]]);
               end
            end
         end
         S_DRAIN: begin
            if (w_stop) begin
               state_d  = S_DONE;
               result_d = w_stop_res;
            end else if (timer_q == C_DRAIN_LAST) begin
               state_d  = S_DONE;
               result_d = C_RES_EXH;
            end else begin
               timer_d = timer_q + C_TW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      game_reset_d = (state_d == S_GRST);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
      load_ready_d = (state_d == S_IDLE) && (count_d < C_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         moves_q      <= '0;
         rd_ptr_q     <= '0;
         timer_q      <= '0;
         result_q     <= C_RES_ABORT;
         dir_q        <= 4'b0000;
         game_reset_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         moves_q      <= moves_d;
         rd_ptr_q     <= rd_ptr_d;
         timer_q      <= timer_d;
         result_q     <= result_d;
         dir_q        <= dir_d;
         game_reset_q <= game_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_ready_q <= load_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         buf_q[count_q[C_AW-1:0]] <= load_dir;
      end
   end

   assign load_ready = load_ready_q;
   assign game_reset = game_reset_q;
   assign n          = dir_q[3];
   assign s          = dir_q[2];
   assign e          = dir_q[1];
   assign w          = dir_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign result     = result_q;
   assign count      = count_q;
   assign moves      = moves_q;

endmodule
`default_nettype wire

// File: tb/tb_game_move_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_game_move_sequencer : randomized and directed runs against a run-level
// outcome model of the move sequencer. Rev 1.0
// ----------------------------------------------------------------------------
module tb_game_move_sequencer;

   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;
   localparam int R      = 5;
   localparam int D      = 2;

   logic             clk = 1'b0;
   logic             reset, load_valid, load_ready, clear, start, abort;
   logic [1:0]       load_dir;
   logic             game_d, game_win, game_reset, n, s, e, w, busy, done;
   logic [1:0]       result;
   logic [CNT_W-1:0] count, moves;
   logic [7:0]       w_ctl;

   game_move_sequencer #(
      .DEPTH(DEPTH), .CNT_W(CNT_W), .RST_CYCLES(R), .DRAIN_CYCLES(D)
   ) u_dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_dir(load_dir),
      .load_ready(load_ready), .clear(clear), .start(start), .abort(abort),
      .game_d(game_d), .game_win(game_win), .game_reset(game_reset),
      .n(n), .s(s), .e(e), .w(w), .busy(busy), .done(done),
      .result(result), .count(count), .moves(moves)
   );

   always #5 clk = ~clk;

   assign w_ctl = {busy, done, game_reset, load_ready, n, s, e, w};

   int         n_tests = 0;
   int         n_fail  = 0;
   int         seq_q[$];
   logic [3:0] c_dir_oh [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic load_all();
      do_clear();
      foreach (seq_q[i]) begin
         load_valid = 1'b1;
         load_dir   = 2'(seq_q[i]);
         @(negedge clk);
      end
      load_valid = 1'b0;
      check("load_count", 32'(count), 32'(seq_q.size()));
      check("load_ready", 32'(load_ready), 32'(seq_q.size() < DEPTH));
   endtask

   // kind: 0 none, 1 win, 2 dead, 3 abort, 4 abort+win, 5 win+dead.
   // Cycle 0 is the first cycle after the start edge; an event driven in
   // cycle ev is seen at the edge closing that cycle.
   task automatic run(input int kind, input int ev);
      int         L, done_at, exp_res, exp_moves;
      bit         ab, wn, dd;
      logic [7:0] exp_vec;
      L  = seq_q.size();
      ab = (kind == 3) || (kind == 4);
      wn = (kind == 1) || (kind == 4) || (kind == 5);
      dd = (kind == 2) || (kind == 5);
      done_at   = R + L + D;
      exp_res   = 3;
      exp_moves = L;
      if (kind != 0) begin
         if (ev < R) begin
            if (ab) begin
               done_at = ev + 1; exp_res = 0; exp_moves = 0;
            end
         end else if (ev < R + L + D) begin
            done_at   = ev + 1;
            exp_res   = ab ? 0 : (wn ? 1 : 2);
            exp_moves = (ev < R + L) ? ev - R : L;
         end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= done_at + 1; c++) begin
         if (c == ev && kind != 0) begin
            abort = ab; game_win = wn; game_d = dd;
         end
         if (c < done_at) begin
            exp_vec = {4'b1000 | ((c < R) ? 4'b0010 : 4'b0000),
                       (c >= R && c < R + L) ? c_dir_oh[seq_q[c - R]] : 4'b0000};
         end else if (c == done_at) begin
            exp_vec = 8'b1100_0000;
         end else begin
            exp_vec = {3'b000, (L < DEPTH) ? 1'b1 : 1'b0, 4'b0000};
         end
         check($sformatf("ctl[c=%0d]", c), 32'(w_ctl), 32'(exp_vec));
         if (c == 0) check("moves_clr", 32'(moves), 0);
         if (c == done_at) begin
            check("result", 32'(result), 32'(exp_res));
            check("moves", 32'(moves), 32'(exp_moves));
         end
         @(negedge clk);
         abort = 1'b0; game_win = 1'b0; game_d = 1'b0;
      end
      check("count_kept", 32'(count), 32'(L));
   endtask

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_dir = 2'b00; clear = 1'b0;
      start = 1'b0; abort = 1'b0; game_d = 1'b0; game_win = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ctl", 32'(w_ctl), 32'h10);
      check("rst_res", 32'(result), 0);
      check("rst_cnt", 32'({count, moves}), 0);
      reset = 1'b0;
      @(negedge clk);

      // E,E,S,S,E then win in the first drain cycle
      seq_q = '{2, 2, 1, 1, 2};
      load_all();
      run(1, R + 5);

      // N,W,W with dead seen together with the third move
      seq_q = '{0, 3, 3};
      load_all();
      run(2, R + 2);

      // single S, no outcome: exhausted, then replay
      seq_q = '{1};
      load_all();
      run(0, 0);
      run(0, 0);

      // reset in the middle of play
      seq_q = '{0, 1, 2, 3, 0, 1, 2, 3};
      load_all();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (R + 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_ctl", 32'(w_ctl), 32'h10);
      check("midrst_res", 32'(result), 0);
      check("midrst_cnt", 32'({count, moves}), 0);
      reset = 1'b0;
      seq_q = {};
      @(negedge clk);

      // overfill, clear, empty start
      load_valid = 1'b1;
      repeat (DEPTH + 1) begin
         load_dir = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      load_valid = 1'b0;
      check("full_cnt", 32'(count), 32'(DEPTH));
      check("full_rdy", 32'(load_ready), 0);
      do_clear();
      check("clr_cnt", 32'(count), 0);
      check("clr_rdy", 32'(load_ready), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         check("empty_start", 32'({busy, done}), 0);
         @(negedge clk);
      end

      // 10-move run: abort on the 3rd play cycle, then abort with win
      seq_q = {};
      repeat (10) seq_q.push_back($urandom_range(0, 3));
      load_all();
      run(3, R + 2);
      run(4, R + 4);

      // randomized runs
      repeat (40) begin
         int len;
         len = $urandom_range(1, DEPTH);
         seq_q = {};
         repeat (len) seq_q.push_back($urandom_range(0, 3));
         load_all();
         run($urandom_range(0, 5), $urandom_range(0, R + len + D));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
